// File: rtl/sb_tx_arbiter_pkg.sv
// rtl/sb_tx_arbiter_pkg.sv - sideband codex types shared by the TX arbiter and its round-robin picker
package sb_tx_arbiter_pkg;

    localparam int SB_ARB_MAX_REQ = 8;

    typedef logic [7:0] SB_msg_t;

    typedef enum logic [1:0] {
        SB_PLEN_NONE = 2'd0,
        SB_PLEN_32   = 2'd1,
        SB_PLEN_64   = 2'd2
    } sb_plen_t;

    typedef enum logic [1:0] {
        SB_ARB_IDLE = 2'd0,
        SB_ARB_HDR  = 2'd1,
        SB_ARB_DATA = 2'd2
    } sb_arb_state_t;

    // Reserved length code 3 carries no payload.
    function automatic logic plen_has_data(input logic [1:0] plen);
        return (plen == SB_PLEN_32) || (plen == SB_PLEN_64);
    endfunction

    // A 32-bit payload travels in the low half with the upper half zeroed.
    function automatic logic [63:0] format_payload(input logic [1:0] plen, input logic [63:0] data);
        return (plen == SB_PLEN_64) ? data : {32'd0, data[31:0]};
    endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// rtl/sb_rr_arbiter.sv - combinational round-robin picker searching upward from a pointer with wrap
module sb_rr_arbiter
    import sb_tx_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    input  logic [N-1:0] mask,
    output logic [N-1:0] grant,
    output logic [2:0]   idx
);

    int best_off;
    int off;

    // The eligible requester closest to the pointer (distance measured upward, wrapping) wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        best_off = N;
        off      = 0;
        for (int i = 0; i < N; i++) begin
            off = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
            if (req[i] && mask[i] && (off < best_off)) begin
                best_off = off;
                grant    = '0;
                grant[i] = 1'b1;
                idx      = 3'(i);
            end
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// rtl/sb_tx_arbiter.sv - sideband TX arbiter and header/data beat sequencer; SB_TX_ARB_PRIO0_EN gives source 0 strict priority
module sb_tx_arbiter
    import sb_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                         clk_100MHz,
    input  logic                         reset_n,
    input  logic                         enable_i,
    input  logic [NUM_REQ-1:0]           req_i,
    input  SB_msg_t [NUM_REQ-1:0]        msg_i,
    input  logic [NUM_REQ-1:0][1:0]      plen_i,
    input  logic [NUM_REQ-1:0][63:0]     data_i,
    output logic [NUM_REQ-1:0]           ack_o,
    input  logic                         ready_i,
    output logic                         valid_o,
    output SB_msg_t                      SB_msg_o,
    output logic [63:0]                  dataBus_o,
    output logic                         busy_o,
    output logic [2:0]                   gnt_idx_o
);

    sb_arb_state_t      state;
    logic [2:0]         rr_ptr;
    logic [1:0]         plen_q;
    logic [63:0]        data_q;

    logic [NUM_REQ-1:0] rr_mask;
    logic [NUM_REQ-1:0] rr_grant;
    logic [2:0]         rr_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [2:0]         win_idx;
    logic               ptr_update;
    logic               grant_now;
    logic [2:0]         ptr_next;
    SB_msg_t            win_msg;
    logic [1:0]         win_plen;
    logic [63:0]        win_data;

    sb_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_i),
        .ptr   (rr_ptr),
        .mask  (rr_mask),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

`ifdef SB_TX_ARB_PRIO0_EN
    assign rr_mask = {{(NUM_REQ-1){1'b1}}, 1'b0};

    // Source 0 pre-empts the rotation and leaves the pointer where it was.
    always_comb begin
        win_onehot = rr_grant;
        win_idx    = rr_idx;
        ptr_update = 1'b1;
        if (req_i[0]) begin
            win_onehot = NUM_REQ'(1);
            win_idx    = 3'd0;
            ptr_update = 1'b0;
        end
    end
`else
    assign rr_mask = '1;

    // Every grant comes from the rotation and advances the pointer.
    always_comb begin
        win_onehot = rr_grant;
        win_idx    = rr_idx;
        ptr_update = 1'b1;
    end
`endif

    assign grant_now = (state == SB_ARB_IDLE) && enable_i && (|win_onehot);
    assign ack_o     = grant_now ? win_onehot : '0;
    assign ptr_next  = (win_idx == 3'(NUM_REQ-1)) ? 3'd0 : win_idx + 3'd1;

    // Select the winner's message fields with the one-hot grant.
    always_comb begin
        win_msg  = '0;
        win_plen = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_msg  = win_msg  | msg_i[i];
                win_plen = win_plen | plen_i[i];
                win_data = win_data | data_i[i];
            end
        end
    end

    // Grant/capture in IDLE, then present header and optional payload beats until each is accepted.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SB_ARB_IDLE;
            rr_ptr    <= 3'd0;
            plen_q    <= 2'd0;
            data_q    <= 64'd0;
            valid_o   <= 1'b0;
            SB_msg_o  <= '0;
            dataBus_o <= 64'd0;
            busy_o    <= 1'b0;
            gnt_idx_o <= 3'd0;
        end else begin
            case (state)
                SB_ARB_IDLE: begin
                    if (grant_now) begin
                        SB_msg_o  <= win_msg;
                        plen_q    <= win_plen;
                        data_q    <= win_data;
                        gnt_idx_o <= win_idx;
                        if (ptr_update) begin
                            rr_ptr <= ptr_next;
                        end
                        dataBus_o <= 64'd0;
                        valid_o   <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= SB_ARB_HDR;
                    end
                end
                SB_ARB_HDR: begin
                    if (ready_i) begin
                        if (plen_has_data(plen_q)) begin
                            dataBus_o <= format_payload(plen_q, data_q);
                            state     <= SB_ARB_DATA;
                        end else begin
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            state   <= SB_ARB_IDLE;
                        end
                    end
                end
                SB_ARB_DATA: begin
                    if (ready_i) begin
                        dataBus_o <= 64'd0;
                        valid_o   <= 1'b0;
                        busy_o    <= 1'b0;
                        state     <= SB_ARB_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state   <= SB_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb/tb_sb_tx_arbiter.sv - self-checking bench for sb_tx_arbiter (optionally built with SB_TX_ARB_PRIO0_EN)
module tb_sb_tx_arbiter;

    localparam int NR = 3;

    logic                  clk_100MHz = 1'b0;
    logic                  reset_n;
    logic                  enable_i;
    logic [NR-1:0]         req_i;
    logic [NR-1:0][7:0]    msg_i;
    logic [NR-1:0][1:0]    plen_i;
    logic [NR-1:0][63:0]   data_i;
    logic [NR-1:0]         ack_o;
    logic                  ready_i;
    logic                  valid_o;
    logic [7:0]            SB_msg_o;
    logic [63:0]           dataBus_o;
    logic                  busy_o;
    logic [2:0]            gnt_idx_o;

    always #5 clk_100MHz = ~clk_100MHz;

    sb_tx_arbiter #(.NUM_REQ(NR)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .enable_i   (enable_i),
        .req_i      (req_i),
        .msg_i      (msg_i),
        .plen_i     (plen_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .SB_msg_o   (SB_msg_o),
        .dataBus_o  (dataBus_o),
        .busy_o     (busy_o),
        .gnt_idx_o  (gnt_idx_o)
    );

    typedef struct {
        logic [7:0]  msg;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        int          src;
        logic [7:0]  msg;
        logic [1:0]  plen;
        logic [63:0] data;
        bit          has_data;
        logic [63:0] exp_data;
        bit          stall;
    } vec_t;

    int checks = 0;
    int errors = 0;
    beat_t beat_q[$];
    logic [NR-1:0] ack_q[$];
    int idx_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable_i = 1'b1;
        ready_i  = 1'b1;
        req_i    = '0;
        msg_i    = '0;
        plen_i   = '0;
        data_i   = '0;
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    task automatic push_beat(input logic [7:0] msg, input logic [63:0] data);
        beat_t b;
        b.msg  = msg;
        b.data = data;
        beat_q.push_back(b);
    endtask

    task automatic drain(input bit stall, input int max_cycles);
        int n = 0;
        int stall_left = 0;
        while (beat_q.size() > 0 && n < max_cycles) begin
            @(negedge clk_100MHz);
            n++;
            if (stall_left > 0) begin
                ready_i = 1'b0;
                stall_left--;
            end else begin
                ready_i = 1'b1;
            end
            if (n == 1) check("hdr_latency_valid", valid_o, 1'b1);
            if (valid_o) begin
                check("beat_msg", SB_msg_o, beat_q[0].msg);
                check("beat_data", dataBus_o, beat_q[0].data);
                if (ready_i) begin
                    void'(beat_q.pop_front());
                    if (stall && beat_q.size() > 0) stall_left = 1;
                end
            end
        end
        ready_i = 1'b1;
        if (beat_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: %0d beats outstanding, expected 0", beat_q.size());
            beat_q.delete();
        end
    endtask

    task automatic idle_checks();
        @(negedge clk_100MHz);
        check("idle_valid", valid_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
    endtask

    task automatic send_one(input vec_t v);
        @(negedge clk_100MHz);
        ready_i          = 1'b1;
        msg_i[v.src]     = v.msg;
        plen_i[v.src]    = v.plen;
        data_i[v.src]    = v.data;
        req_i            = NR'(1) << v.src;
        #1;
        check("ack", ack_o, NR'(1) << v.src);
        push_beat(v.msg, 64'd0);
        if (v.has_data) push_beat(v.msg, v.exp_data);
        @(posedge clk_100MHz);
        #1;
        req_i         = '0;
        msg_i[v.src]  = ~v.msg;
        data_i[v.src] = ~v.data;
        plen_i[v.src] = 2'd0;
        check("gnt_idx", gnt_idx_o, v.src);
        drain(v.stall, 12);
        idle_checks();
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] prev_ack;
        int pend_idx;
        int n;

        vecs[0] = '{0, 8'h11, 2'd0, 64'h1111_2222_3333_4444, 1'b0, 64'd0, 1'b0};
        vecs[1] = '{2, 8'h22, 2'd2, 64'hDEAD_BEEF_0123_4567, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1};
        vecs[2] = '{1, 8'h33, 2'd1, 64'hFFFF_FFFF_A5A5_5A5A, 1'b1, 64'h0000_0000_A5A5_5A5A, 1'b0};
        vecs[3] = '{0, 8'h44, 2'd3, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 64'd0, 1'b0};
        vecs[4] = '{1, 8'h55, 2'd1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b1};
        vecs[5] = '{2, 8'h66, 2'd2, 64'h5555_AAAA_0F0F_F0F0, 1'b1, 64'h5555_AAAA_0F0F_F0F0, 1'b0};

        // reset state
        do_reset();
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ack", ack_o, '0);
        check("rst_msg", SB_msg_o, 8'h00);
        check("rst_data", dataBus_o, 64'd0);
        check("rst_gnt_idx", gnt_idx_o, 3'd0);

        // table of single-source messages
        for (int i = 0; i < 6; i++) send_one(vecs[i]);

        // fairness with all requesters continuously asserted
        do_reset();
`ifdef SB_TX_ARB_PRIO0_EN
        ack_q = '{3'b001, 3'b001, 3'b001, 3'b001};
        idx_q = '{0, 0, 0, 0};
`else
        ack_q = '{3'b001, 3'b010, 3'b100, 3'b001};
        idx_q = '{0, 1, 2, 0};
`endif
        @(negedge clk_100MHz);
        msg_i    = {8'hC2, 8'hC1, 8'hC0};
        plen_i   = '0;
        req_i    = '1;
        prev_ack = '0;
        pend_idx = -1;
        n        = 0;
        while (ack_q.size() > 0 && n < 30) begin
            #1;
            if (pend_idx >= 0) begin
                check("rr_gnt_idx", gnt_idx_o, pend_idx);
                pend_idx = -1;
            end
            if (ack_o != '0) begin
                check("ack_spacing", prev_ack, '0);
                check("rr_ack", ack_o, ack_q.pop_front());
                pend_idx = idx_q.pop_front();
            end
            prev_ack = ack_o;
            @(negedge clk_100MHz);
            n++;
        end
        if (ack_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: %0d grants outstanding, expected 0", ack_q.size());
        end
        req_i = '0;
        repeat (3) @(negedge clk_100MHz);

        // enable dropped during a data-bearing header
        do_reset();
        @(negedge clk_100MHz);
        msg_i  = {8'hA2, 8'h5A, 8'hA0};
        plen_i = {2'd0, 2'd2, 2'd0};
        data_i[1] = 64'h0BAD_CAFE_1234_5678;
        req_i  = 3'b010;
        #1;
        check("en_ack", ack_o, 3'b010);
        push_beat(8'h5A, 64'd0);
        push_beat(8'h5A, 64'h0BAD_CAFE_1234_5678);
        @(posedge clk_100MHz);
        #1;
        enable_i = 1'b0;
        req_i    = 3'b101;
        drain(1'b0, 10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_100MHz);
            check("no_ack_disabled", ack_o, '0);
        end
        enable_i = 1'b1;
        #1;
`ifdef SB_TX_ARB_PRIO0_EN
        check("en_resume_ack", ack_o, 3'b001);
        push_beat(8'hA0, 64'd0);
`else
        check("en_resume_ack", ack_o, 3'b100);
        push_beat(8'hA2, 64'd0);
`endif
        @(posedge clk_100MHz);
        #1;
        req_i = '0;
        drain(1'b0, 10);
        idle_checks();

        // reset asserted in the DATA state
        do_reset();
        @(negedge clk_100MHz);
        msg_i     = {8'hB2, 8'h77, 8'hB0};
        plen_i    = {2'd0, 2'd2, 2'd0};
        data_i[1] = 64'h1357_9BDF_2468_ACE0;
        req_i     = 3'b010;
        #1;
        check("rstmid_ack", ack_o, 3'b010);
        @(posedge clk_100MHz);
        #1;
        req_i = '0;
        @(negedge clk_100MHz);
        check("rstmid_hdr_valid", valid_o, 1'b1);
        @(negedge clk_100MHz);
        ready_i = 1'b0;
        check("rstmid_data_valid", valid_o, 1'b1);
        check("rstmid_data", dataBus_o, 64'h1357_9BDF_2468_ACE0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_async_valid", valid_o, 1'b0);
        check("rstmid_async_busy", busy_o, 1'b0);
        check("rstmid_async_data", dataBus_o, 64'd0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        ready_i = 1'b1;
        req_i   = 3'b111;
        #1;
        check("ptr_reset_ack", ack_o, 3'b001);
        push_beat(8'hB0, 64'd0);
        @(posedge clk_100MHz);
        #1;
        req_i = '0;
        drain(1'b0, 10);
        @(negedge clk_100MHz);
        req_i = 3'b100;
        #1;
        check("post_rst_ack", ack_o, 3'b100);
        push_beat(8'hB2, 64'd0);
        @(posedge clk_100MHz);
        #1;
        req_i = '0;
        check("post_rst_gnt_idx", gnt_idx_o, 3'd2);
        drain(1'b0, 10);
        idle_checks();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_tx_arbiter.md
# sb_tx_arbiter

Arbitrates sideband transmit access among NUM_REQ message sources (LTSM, RDI and FDI message generators) and sequences the shared sideband transmitter. It captures one complete message per grant: the header, plus the optional 32- or 64-bit data payload. It then presents that message to the transmitter as an uninterruptible header/data beat pair, so payloads from different sources never interleave. It sits between the message sources and the sideband TX serializer in the 100 MHz domain.

## Interface
- NUM_REQ, default 3: number of requesters, 2..8.
- clk_100MHz  in  1  sideband message clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  link sideband enable; when low, no new grants are made.
- req_i  in  NUM_REQ  per-source request, level.
- msg_i  in  NUM_REQ x SB_msg_t  per-source message code.
- plen_i  in  NUM_REQ x 2  per-source payload length as sb_plen_t: 0 none, 1 32b, 2 64b, 3 reserved (treated as none).
- data_i  in  NUM_REQ x 64  per-source payload.
- ack_o  out  NUM_REQ  one-cycle pulse; the source's message was captured.
- ready_i  in  1  transmitter ready for a beat (the transmitter's send-next flag).
- valid_o  out  1  beat valid toward the transmitter.
- SB_msg_o  out  SB_msg_t  header beat message code.
- dataBus_o  out  64  payload beat data.
- busy_o  out  1  a message is held or in flight.
- gnt_idx_o  out  3  index of the current or last grant.

## Operation
- States:
  - IDLE: no message held.
  - HDR: header beat presented.
  - DATA: payload beat presented.
- Reset values:
  - state IDLE; round-robin pointer 0.
  - all outputs 0; capture registers 0.
- IDLE, when enable_i=1 and any req_i is set:
  - pick the winner round-robin, searching from the pointer upward with wrap-around.
  - capture msg_i, plen_i and data_i of the winner.
  - pulse ack_o[winner].
  - set pointer to winner+1, wrapping NUM_REQ-1 -> 0.
  - go to HDR.
- HDR:
  - valid_o=1; SB_msg_o = captured msg; dataBus_o = 0.
  - on a beat accepted (valid_o && ready_i at the edge): go to DATA if plen is 1 or 2, else go to IDLE.
- DATA:
  - valid_o=1; SB_msg_o holds the captured msg.
  - dataBus_o = {32'd0, data[31:0]} for plen 1, or the full data for plen 2.
  - on a beat accepted: go to IDLE.
- busy_o = (state != IDLE).
- gnt_idx_o updates at capture and holds until the next grant.
- A source may drop or change req_i and its inputs any time after its ack_o; the captured copy is used.
- A request withdrawn before its ack has no effect.
- enable_i falling mid-message does not abort it; the held message completes.
- Reset asserted mid-message discards the message immediately.
- Requests that are never granted are never acked.

## Timing
- Latency, grant to header: ack_o in cycle T; valid_o first high in cycle T+1.
- Minimum message spacing: header-only messages take 2 cycles each (IDLE grant, then HDR accept); header+data messages take 3 cycles.
- ready_i low holds the current beat stable: valid_o, SB_msg_o and dataBus_o do not change.
- The transmitter deasserts ready_i for one cycle after a data-bearing header. The DATA beat then waits without bubbles or duplication.
- Re-arbitration happens only in IDLE. ack_o is never high in two consecutive cycles.
- Fairness: with all NUM_REQ requesting continuously, each source is granted once every NUM_REQ grants.

## Configuration
- SB_TX_ARB_PRIO0_EN:
  - Defined: requester 0 (LTSM) has strict priority. It wins every IDLE arbitration in which req_i[0]=1, and the pointer is not updated on its grants. The remaining sources are round-robin among themselves.
  - Undefined: pure round-robin across all sources.

## Structure
- Shared package (extend the existing sideband codex package):
  - sb_plen_t enum: SB_PLEN_NONE, SB_PLEN_32, SB_PLEN_64.
  - state enum sb_arb_state_t.
  - SB_ARB_MAX_REQ = 8.
- Sub-module sb_rr_arbiter:
  - inputs: request vector, pointer, mask.
  - outputs: one-hot grant and grant index.
  - purely combinational; instantiated once.
- sb_tx_arbiter holds the FSM, the capture registers and the pointer.

## Test plan
- Single header-only request: req_i=001, msg=MSG_A, plen 0, ready_i=1 -> ack_o=001 at T; valid_o=1 with SB_msg_o=MSG_A at T+1; busy_o=0 at T+2.
- 64b payload with transmitter stall: plen 2, data=64'hDEAD_BEEF_0123_4567, ready_i low in the cycle after header acceptance -> DATA beat holds 64'hDEAD_BEEF_0123_4567 until ready_i=1, then IDLE.
- 32b payload: data=64'hFFFF_FFFF_A5A5_5A5A, plen 1 -> dataBus_o = 64'h0000_0000_A5A5_5A5A.
- All three requesting continuously, NUM_REQ=3 -> ack_o sequence 001, 010, 100, 001; gnt_idx_o 0, 1, 2, 0. With SB_TX_ARB_PRIO0_EN defined -> 001 on every grant.
- enable_i dropped during HDR of a plen-2 message -> header and data beats both complete; no further ack_o while enable_i=0.
- reset_n asserted in DATA state -> valid_o=0, busy_o=0, pointer=0 asynchronously. After release, req_i=100 gets ack_o=100.
